uart_reg_bank: RTL and testbench
================================

# uart_reg_bank

Register bank and data buffering that sits directly downstream of the APB slave bridge in the UART. It decodes the bridge's simple write and read strobes and drives the bridge's acknowledge and error lines. It holds the UART configuration registers and buffers transmit and receive bytes in two synchronous FIFOs between the bus and the UART TX/RX engines. It also generates the UART interrupt.

## Interface
Parameters:
- FIFO_DEPTH, 16, entries per TX and RX FIFO; power of two, at least 2
- DIV_RST, 16'd27, reset value of the baud divisor

Ports:
- Clock and reset: single clock `pclk`; reset `prst_n` is synchronous and active-low.
- pclk  in  1  clock
- prst_n  in  1  synchronous active-low reset
- waddr  in  12  write byte address, valid while wr_en=1
- wdata  in  32  write data, valid while wr_en=1
- wr_en  in  1  one-cycle write strobe
- raddr  in  12  read byte address, valid while rd_en=1
- rd_en  in  1  read request level, held until rack
- wack  out  1  write acknowledge, one cycle
- rack  out  1  read acknowledge, one cycle, qualifies rdata
- rdata  out  32  read data
- waddrerr  out  1  write error, only together with wack
- raddrerr  out  1  read error, only together with rack
- tx_data  out  8  head of TX FIFO
- tx_valid  out  1  TX FIFO not empty
- tx_ready  in  1  TX engine consumes tx_data when tx_valid&tx_ready
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle received-byte strobe
- baud_div  out  16  baud divisor
- cfg  out  8  LCR contents to the TX/RX engines
- irq  out  1  interrupt

## Operation
Register map. Word aligned; any access with addr[1:0]≠0 is an error. Unlisted fields read 0.
- 0x000 LCR, RW, [7:0]: [1:0] data bits 5–8, [2] stop2, [3] par_en, [4] par_odd, [5] tx_en, [6] rx_en. Reset 0.
- 0x004 DIV, RW, [15:0] drives baud_div. Reset DIV_RST.
- 0x008 IER, RW, [2:0]: tx_empty_ie, rx_avail_ie, ovr_ie. Reset 0.
- 0x00C FSR, RO except W1C on bit 4.
  - [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] ovr (sticky).
  - [12:8] tx_count, [20:16] rx_count.
- 0x010 TBR, WO: wdata[7:0] pushed to TX FIFO.
- 0x014 RBR, RO: pops the RX FIFO; rdata = {24'b0, byte}.

Error rules:
- Writes to RO registers, unmapped or misaligned addresses: wack with waddrerr=1; no state change.
- Writes to FSR: W1C on bit 4 only, no error.
- Write to TBR while the TX FIFO is full: wack with waddrerr=1; the byte is dropped.
- Reads of TBR, unmapped or misaligned addresses: rack with raddrerr=1 and rdata=0.
- Read of RBR while the RX FIFO is empty: rack, rdata=0, no error, no pop.

RX path:
- rx_valid while the RX FIFO is full: the byte is dropped and ovr is set.
- If ovr set by hardware and W1C happen in the same cycle, set wins.

Interrupt: irq = (IER[0]&tx_empty) | (IER[1]&~rx_empty) | (IER[2]&ovr). irq is registered.

## Timing
- Reset values: wack, rack, waddrerr, raddrerr, rdata, irq = 0. Both FIFOs empty, so tx_valid=0. baud_div = DIV_RST, cfg = 0.
- Write, cycle N (wr_en=1):
  - wack=1 and waddrerr are driven combinationally in cycle N.
  - The register update or FIFO push is visible from N+1.
  - Exactly one action per wr_en cycle.
- Read, cycle N (rd_en=1, rack=0):
  - rdata, rack and raddrerr are registered and appear in N+1 for one cycle.
  - An RBR pop happens at the end of cycle N.
  - While rack=1, rd_en is ignored. A held rd_en therefore never causes a second read or pop.
- rdata returns to 0 in the cycle after rack.
- FSR contents are sampled in cycle N.
- FIFO rules, applied to both FIFOs:
  - Push is allowed when not full, pop when not empty. full and empty are evaluated on pre-cycle state.
  - Simultaneous push and pop on a non-empty, non-full FIFO leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH. The count is $clog2(FIFO_DEPTH)+1 bits wide.
- The TX FIFO is popped when tx_valid&tx_ready. tx_data is the registered head entry and is valid whenever tx_valid=1.
- irq lags status changes by one cycle.
- Reset asserted mid-transaction:
  - The pending rack is cancelled and the FIFOs are cleared in the next cycle.
  - No ack is issued for that transaction.

## Structure
- Package uart_reg_pkg holds:
  - address localparams ADDR_LCR … ADDR_RBR;
  - FSR bit-index constants;
  - a packed struct lcr_t for the LCR fields.
- One sub-module, uart_sync_fifo, with parameters WIDTH and DEPTH:
  - ports push, pop, din, dout, full, empty, count;
  - synchronous active-low reset;
  - instantiated twice, for TX and RX.
- Address decode, registers, ack/err generation and irq live in the top level.

## Test plan
- Write DIV 0x0000_1234, then read DIV: wack N, DIV reads 0x1234 with rack at N+1, no errors; baud_div=0x1234.
- Write TBR 0x41, 0x42, then drive tx_ready=1: tx_data emits 0x41 then 0x42; FSR tx_count goes 2→0; tx_empty=1.
- 17 TBR writes with tx_ready=0: writes 1–16 get wack only; write 17 gets waddrerr=1; FSR tx_full=1, tx_count=16.
- 17 rx_valid pulses with IER=3'b100: ovr=1, irq=1 one cycle later. Write FSR 0x10: ovr=0, irq=0. 16 RBR reads return the bytes in order.
- rd_en held 3 cycles on RBR: exactly one rack and one pop. A read at 0x020 gives raddrerr=1, rdata=0. A write at 0x002 gives waddrerr=1.
- Assert prst_n=0 with the RX FIFO holding 3 bytes and a read pending: next cycle rack=0, rx_empty=1, LCR=0, baud_div=27.

Source files
------------

// File: rtl/uart_reg_pkg.sv
// Shared definitions for the UART register bank: register addresses,
// FSR bit positions, the LCR field layout and the address decoder.
package uart_reg_pkg;

  localparam logic [11:0] ADDR_LCR = 12'h000;
  localparam logic [11:0] ADDR_DIV = 12'h004;
  localparam logic [11:0] ADDR_IER = 12'h008;
  localparam logic [11:0] ADDR_FSR = 12'h00C;
  localparam logic [11:0] ADDR_TBR = 12'h010;
  localparam logic [11:0] ADDR_RBR = 12'h014;

  localparam int FSR_TX_FULL    = 0;
  localparam int FSR_TX_EMPTY   = 1;
  localparam int FSR_RX_FULL    = 2;
  localparam int FSR_RX_EMPTY   = 3;
  localparam int FSR_OVR        = 4;
  localparam int FSR_TX_CNT_LSB = 8;
  localparam int FSR_RX_CNT_LSB = 16;
  localparam int FSR_CNT_W      = 5;

  localparam int IER_TX_EMPTY = 0;
  localparam int IER_RX_AVAIL = 1;
  localparam int IER_OVR      = 2;

  // Line control register; bit 7 is unused and always held at 0.
  typedef struct packed {
    logic       rsvd;
    logic       rx_en;
    logic       tx_en;
    logic       par_odd;
    logic       par_en;
    logic       stop2;
    logic [1:0] data_bits;
  } lcr_t;

  typedef enum logic [2:0] {
    REG_LCR,
    REG_DIV,
    REG_IER,
    REG_FSR,
    REG_TBR,
    REG_RBR,
    REG_NONE
  } reg_sel_e;

  // Misaligned and unmapped addresses both map to REG_NONE.
  function automatic reg_sel_e decode_addr(input logic [11:0] addr);
    reg_sel_e sel;
    sel = REG_NONE;
    if (addr[1:0] == 2'b00) begin
      case (addr)
        ADDR_LCR: sel = REG_LCR;
        ADDR_DIV: sel = REG_DIV;
        ADDR_IER: sel = REG_IER;
        ADDR_FSR: sel = REG_FSR;
        ADDR_TBR: sel = REG_TBR;
        ADDR_RBR: sel = REG_RBR;
        default:  sel = REG_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO used for the UART TX and RX byte buffers.
// dout shows the head entry straight from the storage flops.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       pclk,
  input  logic                       prst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  // full/empty come from the registered count, i.e. pre-cycle state.
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr_q];
  assign count   = count_q;

  // Storage write.
  // NOTE: the data array is deliberately not reset; the pointers and count
  // define which entries are valid, and leaving it unreset lets it map to RAM.
  always_ff @(posedge pclk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= din;
    end
  end

  // Pointer and occupancy tracking; pointers wrap modulo DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge pclk) begin
    if (!prst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_reg_bank.sv
// UART register bank: decodes bridge read/write strobes, holds LCR/DIV/IER,
// reports FIFO status, buffers TX/RX bytes and generates the interrupt.
module uart_reg_bank
  import uart_reg_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RST    = 16'd27
) (
  input  logic        pclk,
  input  logic        prst_n,
  input  logic [11:0] waddr,
  input  logic [31:0] wdata,
  input  logic        wr_en,
  input  logic [11:0] raddr,
  input  logic        rd_en,
  output logic        wack,
  output logic        rack,
  output logic [31:0] rdata,
  output logic        waddrerr,
  output logic        raddrerr,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] baud_div,
  output logic [7:0]  cfg,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  lcr_t        lcr_q;
  logic [15:0] div_q;
  logic [2:0]  ier_q;
  logic        ovr_q;
  logic        rack_q;
  logic        raddrerr_q;
  logic [31:0] rdata_q;
  logic        irq_q;
  logic        rd_lock_q;

  reg_sel_e    wr_sel;
  reg_sel_e    rd_sel;
  logic        wr_err;
  logic        tx_push;
  logic        tx_pop;
  logic        rx_pop;
  logic        rd_fire;
  logic        rd_err;
  logic [31:0] rd_word;
  logic [31:0] fsr;

  logic [7:0]    tx_dout;
  logic [7:0]    rx_dout;
  logic          tx_full;
  logic          tx_empty;
  logic          rx_full;
  logic          rx_empty;
  logic [CW-1:0] tx_count;
  logic [CW-1:0] rx_count;

  logic unused_wdata;
  assign unused_wdata = ^wdata[31:16];

  assign wr_sel = decode_addr(waddr);
  assign rd_sel = decode_addr(raddr);

  // Write decode: pick the error flag and whether the TX FIFO is pushed.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    wr_err  = 1'b0;
    tx_push = 1'b0;
    if (wr_en) begin
      case (wr_sel)
        REG_LCR, REG_DIV, REG_IER, REG_FSR: wr_err = 1'b0;
        REG_TBR: begin
          if (tx_full) wr_err  = 1'b1;
          else         tx_push = 1'b1;
        end
        default: wr_err = 1'b1;
      endcase
    end
  end

  // A write is acknowledged in the same cycle; nothing is acked under reset.
  assign wack     = wr_en & prst_n;
  assign waddrerr = wr_en & prst_n & wr_err;

  // Configuration registers.
  always_ff @(posedge pclk) begin
    if (!prst_n) begin
      lcr_q <= '0;
      div_q <= DIV_RST;
      ier_q <= '0;
    end else if (wr_en) begin
      case (wr_sel)
        REG_LCR: lcr_q <= lcr_t'({1'b0, wdata[6:0]});
        REG_DIV: div_q <= wdata[15:0];
        REG_IER: ier_q <= wdata[2:0];
        default: ;
      endcase
    end
  end

  // Sticky RX overrun flag; a hardware set beats a same-cycle W1C.
  always_ff @(posedge pclk) begin
    if (!prst_n) begin
      ovr_q <= 1'b0;
    end else if (rx_valid && rx_full) begin
      ovr_q <= 1'b1;
    end else if (wr_en && (wr_sel == REG_FSR) && wdata[FSR_OVR]) begin
      ovr_q <= 1'b0;
    end
  end

  // Live FIFO status word.
  always_comb begin
    fsr                                    = '0;
    fsr[FSR_TX_FULL]                       = tx_full;
    fsr[FSR_TX_EMPTY]                      = tx_empty;
    fsr[FSR_RX_FULL]                       = rx_full;
    fsr[FSR_RX_EMPTY]                      = rx_empty;
    fsr[FSR_OVR]                           = ovr_q;
    fsr[FSR_TX_CNT_LSB +: FSR_CNT_W]       = FSR_CNT_W'(tx_count);
    fsr[FSR_RX_CNT_LSB +: FSR_CNT_W]       = FSR_CNT_W'(rx_count);
  end

  // A read fires once per request: it is blocked while rack is out and
  // stays locked until the bridge drops rd_en, so a held level reads once.
  assign rd_fire = rd_en & ~rack_q & ~rd_lock_q;

  // Read mux and RBR pop request.
  always_comb begin
    rd_err  = 1'b0;
    rd_word = '0;
    rx_pop  = 1'b0;
    case (rd_sel)
      REG_LCR: rd_word = {24'b0, lcr_q};
      REG_DIV: rd_word = {16'b0, div_q};
      REG_IER: rd_word = {29'b0, ier_q};
      REG_FSR: rd_word = fsr;
      REG_RBR: begin
        if (!rx_empty) begin
          rd_word = {24'b0, rx_dout};
          rx_pop  = rd_fire;
        end
      end
      default: rd_err = 1'b1;
    endcase
  end

  // Registered read response; rdata is zero outside the rack cycle.
  always_ff @(posedge pclk) begin
    if (!prst_n) begin
      rack_q     <= 1'b0;
      raddrerr_q <= 1'b0;
      rdata_q    <= '0;
      rd_lock_q  <= 1'b0;
    end else begin
      rack_q     <= rd_fire;
      raddrerr_q <= rd_fire & rd_err;
      rdata_q    <= (rd_fire && !rd_err) ? rd_word : '0;
      rd_lock_q  <= rd_en & (rd_lock_q | rd_fire);
    end
  end

  // Interrupt register, one cycle behind the status it reflects.
  always_ff @(posedge pclk) begin
    if (!prst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= (ier_q[IER_TX_EMPTY] & tx_empty) |
               (ier_q[IER_RX_AVAIL] & ~rx_empty) |
               (ier_q[IER_OVR]      & ovr_q);
    end
  end

  assign tx_pop = tx_valid & tx_ready;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .pclk   (pclk),
    .prst_n (prst_n),
    .push   (tx_push),
    .pop    (tx_pop),
    .din    (wdata[7:0]),
    .dout   (tx_dout),
    .full   (tx_full),
    .empty  (tx_empty),
    .count  (tx_count)
  );

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .pclk   (pclk),
    .prst_n (prst_n),
    .push   (rx_valid),
    .pop    (rx_pop),
    .din    (rx_data),
    .dout   (rx_dout),
    .full   (rx_full),
    .empty  (rx_empty),
    .count  (rx_count)
  );

  assign rack     = rack_q;
  assign raddrerr = raddrerr_q;
  assign rdata    = rdata_q;
  assign irq      = irq_q;
  assign tx_data  = tx_dout;
  assign tx_valid = ~tx_empty;
  assign baud_div = div_q;
  assign cfg      = lcr_q;

endmodule

// File: tb/tb_uart_reg_bank.sv
// Directed self-checking bench for uart_reg_bank.
module tb_uart_reg_bank;
  import uart_reg_pkg::*;

  logic        pclk;
  logic        prst_n;
  logic [11:0] waddr;
  logic [31:0] wdata;
  logic        wr_en;
  logic [11:0] raddr;
  logic        rd_en;
  logic        wack;
  logic        rack;
  logic [31:0] rdata;
  logic        waddrerr;
  logic        raddrerr;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] baud_div;
  logic [7:0]  cfg;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  uart_reg_bank dut (
    .pclk     (pclk),
    .prst_n   (prst_n),
    .waddr    (waddr),
    .wdata    (wdata),
    .wr_en    (wr_en),
    .raddr    (raddr),
    .rd_en    (rd_en),
    .wack     (wack),
    .rack     (rack),
    .rdata    (rdata),
    .waddrerr (waddrerr),
    .raddrerr (raddrerr),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .baud_div (baud_div),
    .cfg      (cfg),
    .irq      (irq)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Starts and ends 1 time unit after a rising edge.
  task automatic bus_write(input logic [11:0] a, input logic [31:0] d,
                           input logic exp_err, input string tag);
    waddr = a;
    wdata = d;
    wr_en = 1'b1;
    #1;
    check({tag, " wack"}, 32'(wack), 32'd1);
    check({tag, " waddrerr"}, 32'(waddrerr), 32'(exp_err));
    @(posedge pclk); #1;
    wr_en = 1'b0;
    wdata = '0;
  endtask

  task automatic bus_read(input logic [11:0] a, input logic [31:0] exp_data,
                          input logic exp_err, input string tag);
    raddr = a;
    rd_en = 1'b1;
    @(posedge pclk); #1;
    check({tag, " rack"}, 32'(rack), 32'd1);
    check({tag, " rdata"}, rdata, exp_data);
    check({tag, " raddrerr"}, 32'(raddrerr), 32'(exp_err));
    rd_en = 1'b0;
    @(posedge pclk); #1;
    check({tag, " rack low"}, 32'(rack), 32'd0);
    check({tag, " rdata cleared"}, rdata, 32'd0);
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge pclk); #1;
    rx_valid = 1'b0;
  endtask

  initial begin
    int racks;
    logic [31:0] held_data;

    prst_n   = 1'b0;
    waddr    = '0;
    wdata    = '0;
    wr_en    = 1'b0;
    raddr    = '0;
    rd_en    = 1'b0;
    tx_ready = 1'b0;
    rx_data  = '0;
    rx_valid = 1'b0;

    // Reset state
    repeat (2) @(posedge pclk);
    #1;
    check("rst wack", 32'(wack), 32'd0);
    check("rst rack", 32'(rack), 32'd0);
    check("rst rdata", rdata, 32'd0);
    check("rst waddrerr", 32'(waddrerr), 32'd0);
    check("rst raddrerr", 32'(raddrerr), 32'd0);
    check("rst irq", 32'(irq), 32'd0);
    check("rst tx_valid", 32'(tx_valid), 32'd0);
    check("rst baud_div", 32'(baud_div), 32'd27);
    check("rst cfg", 32'(cfg), 32'd0);
    prst_n = 1'b1;
    @(posedge pclk); #1;

    // DIV write and readback
    bus_write(ADDR_DIV, 32'h0000_1234, 1'b0, "div wr");
    check("baud_div after wr", 32'(baud_div), 32'h1234);
    bus_read(ADDR_DIV, 32'h0000_1234, 1'b0, "div rd");

    // Two TX bytes then drain
    bus_write(ADDR_TBR, 32'h41, 1'b0, "tbr 41");
    bus_write(ADDR_TBR, 32'h42, 1'b0, "tbr 42");
    check("tx head 41", 32'(tx_data), 32'h41);
    check("tx_valid 2 bytes", 32'(tx_valid), 32'd1);
    bus_read(ADDR_FSR, 32'h0000_0208, 1'b0, "fsr tx2");
    tx_ready = 1'b1;
    @(posedge pclk); #1;
    check("tx head 42", 32'(tx_data), 32'h42);
    check("tx_valid 1 byte", 32'(tx_valid), 32'd1);
    @(posedge pclk); #1;
    check("tx_valid drained", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;
    bus_read(ADDR_FSR, 32'h0000_000A, 1'b0, "fsr tx0");

    // TX overflow: 16 accepted, 17th rejected
    for (int i = 0; i < 16; i++) begin
      bus_write(ADDR_TBR, 32'(8'h10 + i), 1'b0, "tbr fill");
    end
    bus_write(ADDR_TBR, 32'hEE, 1'b1, "tbr overflow");
    bus_read(ADDR_FSR, 32'h0000_1009, 1'b0, "fsr tx full");
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("tx drain order", 32'(tx_data), 32'(8'h10 + i));
      @(posedge pclk); #1;
    end
    check("tx_valid after drain", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;

    // RX overrun and interrupt
    bus_write(ADDR_IER, 32'h4, 1'b0, "ier wr");
    bus_read(ADDR_IER, 32'h4, 1'b0, "ier rd");
    check("irq idle", 32'(irq), 32'd0);
    for (int i = 0; i < 17; i++) begin
      rx_pulse(8'h80 + 8'(i));
    end
    check("irq lags ovr", 32'(irq), 32'd0);
    @(posedge pclk); #1;
    check("irq on ovr", 32'(irq), 32'd1);
    bus_read(ADDR_FSR, 32'h0010_0016, 1'b0, "fsr rx full ovr");
    bus_write(ADDR_FSR, 32'h10, 1'b0, "fsr w1c");
    check("irq lags w1c", 32'(irq), 32'd1);
    @(posedge pclk); #1;
    check("irq cleared", 32'(irq), 32'd0);
    bus_read(ADDR_FSR, 32'h0010_0006, 1'b0, "fsr ovr clr");
    for (int i = 0; i < 16; i++) begin
      bus_read(ADDR_RBR, 32'(8'h80 + i), 1'b0, "rbr order");
    end
    bus_read(ADDR_FSR, 32'h0000_000A, 1'b0, "fsr rx drained");

    // Held rd_en gives one rack and one pop
    rx_pulse(8'hA1);
    rx_pulse(8'hA2);
    raddr     = ADDR_RBR;
    rd_en     = 1'b1;
    racks     = 0;
    held_data = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge pclk); #1;
      if (rack) begin
        racks++;
        held_data = rdata;
      end
    end
    rd_en = 1'b0;
    @(posedge pclk); #1;
    if (rack) racks++;
    check("held rd one rack", 32'(racks), 32'd1);
    check("held rd data", held_data, 32'hA1);
    bus_read(ADDR_FSR, 32'h0001_0002, 1'b0, "fsr one pop");
    bus_read(ADDR_RBR, 32'hA2, 1'b0, "rbr second");
    bus_read(ADDR_RBR, 32'h0, 1'b0, "rbr empty");

    // Error cases
    bus_read(12'h020, 32'h0, 1'b1, "rd unmapped");
    bus_read(ADDR_TBR, 32'h0, 1'b1, "rd tbr");
    bus_write(12'h002, 32'h55, 1'b1, "wr misaligned");
    bus_write(ADDR_RBR, 32'h55, 1'b1, "wr rbr");
    bus_read(ADDR_LCR, 32'h0, 1'b0, "lcr untouched");
    bus_write(ADDR_FSR, 32'hFFFF_FFFF, 1'b0, "fsr wr all");
    bus_read(ADDR_FSR, 32'h0000_000A, 1'b0, "fsr unchanged");

    // LCR and reset mid-transaction
    bus_write(ADDR_LCR, 32'hFF, 1'b0, "lcr wr");
    check("cfg bit7 masked", 32'(cfg), 32'h7F);
    bus_read(ADDR_LCR, 32'h7F, 1'b0, "lcr rd");
    rx_pulse(8'h01);
    rx_pulse(8'h02);
    rx_pulse(8'h03);
    raddr  = ADDR_RBR;
    rd_en  = 1'b1;
    prst_n = 1'b0;
    @(posedge pclk); #1;
    check("rst mid rack", 32'(rack), 32'd0);
    check("rst mid rdata", rdata, 32'd0);
    check("rst mid cfg", 32'(cfg), 32'd0);
    check("rst mid baud_div", 32'(baud_div), 32'd27);
    rd_en  = 1'b0;
    prst_n = 1'b1;
    @(posedge pclk); #1;
    check("post rst rack", 32'(rack), 32'd0);
    bus_read(ADDR_FSR, 32'h0000_000A, 1'b0, "fsr after rst");
    bus_read(ADDR_LCR, 32'h0, 1'b0, "lcr after rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
